// File: rtl/inst_fetch.sv
// Instruction fetch stage: fetches 14-bit words over a req/ack handshake and
// presents them to decode, with stall, branch load and skip handling.
module inst_fetch #(
    parameter int unsigned PC_W = 13,
    parameter int unsigned IW   = 14
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            load_pc,
    input  logic [PC_W-1:0] load_addr,
    input  logic            skip,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [IW-1:0]   mem_data,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      inst_reg,
    output logic [6:0]      f_addr,
    output logic [7:0]      k,
    output logic            valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic            valid_q, valid_d;
    logic            skip_q, skip_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            valid_q <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        valid_d = valid_q;
        skip_d  = skip_q;
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (mem_ack) begin
                    // A skipped word still consumes its slot and advances pc.
                    ir_d    = skip_q ? '0 : mem_data;
                    valid_d = !skip_q;
                    skip_d  = 1'b0;
                    pc_d    = pc_q + 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    state_d = FETCH;
                    if (load_pc) begin
                        pc_d   = load_addr;
                        skip_d = 1'b0;
                    end else if (skip) begin
                        skip_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req  = (state_q == FETCH);
    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign valid    = (state_q == ISSUE) && valid_q;
    assign inst_reg = ir_q[13:6];
    assign f_addr   = ir_q[6:0];
    assign k        = ir_q[7:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Directed cycle-by-cycle bench for inst_fetch: a vector table plus a
// hand-written reset-abort sequence.
module tb_inst_fetch;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        load_pc;
    logic [12:0] load_addr;
    logic        skip;
    logic        mem_req;
    logic [12:0] mem_addr;
    logic        mem_ack;
    logic [13:0] mem_data;
    logic [12:0] pc;
    logic [7:0]  inst_reg;
    logic [6:0]  f_addr;
    logic [7:0]  k;
    logic        valid;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    inst_fetch #(.PC_W(13), .IW(14)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .load_pc   (load_pc),
        .load_addr (load_addr),
        .skip      (skip),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .pc        (pc),
        .inst_reg  (inst_reg),
        .f_addr    (f_addr),
        .k         (k),
        .valid     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        ld;
        logic [12:0] la;
        logic        skip;
        logic        ack;
        logic [13:0] data;
        logic        req;
        logic [12:0] pc;
        logic        vld;
        logic [13:0] ir;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic st, input logic ld, input logic [12:0] la,
                               input logic sk, input logic ack, input logic [13:0] data,
                               input logic req, input logic [12:0] epc,
                               input logic vld, input logic [13:0] ir);
        vec_t r;
        r.stall = st; r.ld = ld; r.la = la; r.skip = sk; r.ack = ack; r.data = data;
        r.req = req; r.pc = epc; r.vld = vld; r.ir = ir;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic req, input logic [12:0] epc,
                             input logic vld, input logic [13:0] ir);
        logic [13:0] irv;
        irv = ir;
        check("mem_req",  idx, 16'(mem_req),  16'(req));
        check("mem_addr", idx, 16'(mem_addr), 16'(epc));
        check("pc",       idx, 16'(pc),       16'(epc));
        check("valid",    idx, 16'(valid),    16'(vld));
        check("inst_reg", idx, 16'(inst_reg), 16'(irv[13:6]));
        check("f_addr",   idx, 16'(f_addr),   16'(irv[6:0]));
        check("k",        idx, 16'(k),        16'(irv[7:0]));
    endtask

    task automatic drive_idle();
        stall = 1'b0; load_pc = 1'b0; load_addr = '0; skip = 1'b0;
        mem_ack = 1'b0; mem_data = '0;
    endtask

    initial begin
        reset = 1'b0;
        drive_idle();

        // Expected outputs are those seen in the cycle; inputs are applied for its closing edge.
        vq.push_back(v(0,0,13'h000,0,0,14'h0000, 0,13'h000,0,14'h0000)); // c0  IDLE
        vq.push_back(v(0,0,13'h000,0,1,14'h0705, 1,13'h000,0,14'h0000)); // c1  zero-wait
        vq.push_back(v(0,0,13'h000,0,0,14'h0000, 0,13'h001,1,14'h0705));
        vq.push_back(v(0,0,13'h000,0,1,14'h1234, 1,13'h001,0,14'h0705));
        vq.push_back(v(0,0,13'h000,0,0,14'h0000, 0,13'h002,1,14'h1234));
        vq.push_back(v(0,0,13'h000,0,1,14'h2A5F, 1,13'h002,0,14'h1234));
        vq.push_back(v(0,0,13'h000,0,0,14'h0000, 0,13'h003,1,14'h2A5F));
        vq.push_back(v(0,0,13'h000,0,1,14'h3FFF, 1,13'h003,0,14'h2A5F));
        vq.push_back(v(0,0,13'h000,0,0,14'h0000, 0,13'h004,1,14'h3FFF)); // c8
        vq.push_back(v(0,0,13'h000,0,0,14'h0000, 1,13'h004,0,14'h3FFF)); // c9  wait states
        vq.push_back(v(0,0,13'h000,0,0,14'h0000, 1,13'h004,0,14'h3FFF));
        vq.push_back(v(0,0,13'h000,0,0,14'h0000, 1,13'h004,0,14'h3FFF));
        vq.push_back(v(0,0,13'h000,0,1,14'h0155, 1,13'h004,0,14'h3FFF));
        vq.push_back(v(1,1,13'h0AA,0,0,14'h0000, 0,13'h005,1,14'h0155)); // c13 stall, load ignored
        vq.push_back(v(1,0,13'h000,1,1,14'h3333, 0,13'h005,1,14'h0155)); // skip/ack ignored
        vq.push_back(v(0,0,13'h000,1,0,14'h0000, 0,13'h005,1,14'h0155)); // retire with skip
        vq.push_back(v(0,0,13'h000,0,1,14'h0999, 1,13'h005,0,14'h0155));
        vq.push_back(v(0,1,13'h100,1,0,14'h0000, 0,13'h006,0,14'h0000)); // c17 skipped slot; branch+skip
        vq.push_back(v(0,0,13'h000,0,1,14'h0ABC, 1,13'h100,0,14'h0000));
        vq.push_back(v(0,1,13'h1FFF,0,0,14'h0000,0,13'h101,1,14'h0ABC)); // branch to top
        vq.push_back(v(0,0,13'h000,0,1,14'h1111, 1,13'h1FFF,0,14'h0ABC));
        vq.push_back(v(0,0,13'h000,0,0,14'h0000, 0,13'h000,1,14'h1111)); // wrapped
        vq.push_back(v(0,0,13'h000,0,0,14'h0000, 1,13'h000,0,14'h1111)); // c22 FETCH

        repeat (3) @(negedge clk);
        check_all(-1, 1'b0, 13'h000, 1'b0, 14'h0000);
        reset = 1'b1;

        foreach (vq[i]) begin
            check_all(i, vq[i].req, vq[i].pc, vq[i].vld, vq[i].ir);
            stall = vq[i].stall; load_pc = vq[i].ld; load_addr = vq[i].la;
            skip = vq[i].skip; mem_ack = vq[i].ack; mem_data = vq[i].data;
            @(negedge clk);
        end
        // Now in the cycle after c22: still FETCH at pc 0 with the request outstanding.
        drive_idle();
        check("abort_pre_req", 100, 16'(mem_req), 16'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("abort_req_drop", 101, 16'(mem_req), 16'd0);
        @(negedge clk);
        mem_ack = 1'b1; mem_data = 14'h2222;
        @(negedge clk);
        mem_ack = 1'b0;
        check_all(102, 1'b0, 13'h000, 1'b0, 14'h0000);
        reset = 1'b1;
        mem_ack = 1'b1; mem_data = 14'h2222;   // ack in IDLE must be ignored
        @(negedge clk);
        mem_ack = 1'b0;
        check_all(103, 1'b1, 13'h000, 1'b0, 14'h0000);
        @(negedge clk);
        check_all(104, 1'b1, 13'h000, 1'b0, 14'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage for the 8-bit core. Reads 14-bit instruction words from program memory over a req/ack handshake at the address held in its internal program counter. Presents each word to `decode` as `inst_reg` plus operand fields, and handles stall, branch load and skip. It is the producer of the instruction stream that `decode` consumes, and it replaces the free-running `pcounter` in the datapath.

## Interface
- `PC_W`, 13: program counter / program memory address width
- `IW`, 14: instruction word width

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `stall`  in  1  hold the current instruction in the issue slot
- `load_pc`  in  1  branch: next fetch comes from `load_addr`
- `load_addr`  in  PC_W  branch target
- `skip`  in  1  the next fetched instruction executes as NOP
- `mem_req`  out  1  program memory read request
- `mem_addr`  out  PC_W  read address; always equals `pc`
- `mem_ack`  in  1  read done; `mem_data` valid in the same cycle
- `mem_data`  in  IW  instruction word
- `pc`  out  PC_W  address of the next instruction to fetch
- `inst_reg`  out  8  `ir[13:6]`: opcode bits plus d bit, for `decode`
- `f_addr`  out  7  `ir[6:0]`: file register address
- `k`  out  8  `ir[7:0]`: literal
- `valid`  out  1  issue slot holds an executable instruction

## Operation
- Internal registers: `ir` (IW bits), `pc`, `skip_pending`, and state.
- States are IDLE, FETCH and ISSUE.
- Reset while `reset`=0, asynchronous:
  - state=IDLE, `pc`=0, `ir`=0 (NOP), `skip_pending`=0.
  - Outputs: `mem_req`=0, `valid`=0, `inst_reg`/`f_addr`/`k`=0.
- IDLE -> FETCH on the first rising edge with `reset`=1.
- `mem_req` = (state==FETCH). It is decoded from the state, so it drops immediately on reset.
- FETCH, `mem_ack`=0: stay. `mem_addr` is held stable.
- FETCH, `mem_ack`=1, on the edge:
  - `ir` <= `skip_pending` ? 0 : `mem_data`.
  - `valid` <= !`skip_pending`; `skip_pending` <= 0.
  - `pc` <= `pc`+1, wrapping modulo 2^PC_W (0x1FFF -> 0).
  - Go to ISSUE.
- `valid` = (state==ISSUE) && the instruction was not skipped. It is 0 in IDLE and FETCH.
- ISSUE, `stall`=1: stay. `ir`, `pc` and `valid` are held. `load_pc` and `skip` are ignored.
- ISSUE, `stall`=0 (instruction retires), go to FETCH and:
  - if `load_pc`: `pc` <= `load_addr` and `skip_pending` <= 0; `skip` is ignored, `load_pc` has priority.
  - else if `skip`: `skip_pending` <= 1.
- `load_pc` and `skip` are sampled only in ISSUE with `stall`=0.
- `mem_ack` is ignored outside FETCH. A late ack after reset or in ISSUE has no effect.
- A skipped word is still fetched and still advances `pc`. It occupies one issue slot with `ir`=0 and `valid`=0.
- `inst_reg`, `f_addr` and `k` are always slices of `ir`.

## Timing
- Zero-wait memory (ack in the first FETCH cycle) gives 2 cycles per instruction: FETCH, then ISSUE.
- Each wait cycle adds 1 cycle. `mem_req` and `mem_addr` stay constant until the ack edge.
- First `mem_req`=1 is in the cycle after the first rising edge following reset release.
- `ir`/`valid` are updated on the ack edge and are visible in the following (ISSUE) cycle.
- A branch costs no extra cycles: the FETCH right after the retiring ISSUE uses `load_addr`.
- Reset asserted mid-fetch (FETCH with the request outstanding) aborts the request; `mem_req` falls in the same cycle.

## Test plan
- Reset and idle: hold `reset`=0 -> `pc`=0, `mem_req`=0, `valid`=0, `inst_reg`=0. Release -> after one edge, `mem_req`=1 and `mem_addr`=0.
- Zero-wait fetch: memory word 0 = 14'h0705, ack in the same cycle.
  - Next cycle: `valid`=1, `inst_reg`=8'h1C, `f_addr`=5, `k`=8'h05, `pc`=1.
  - Sequential words 0..3 issue at a steady 1 per 2 cycles.
- Wait states: ack held off 3 cycles -> `mem_req`=1 and `mem_addr` constant for 4 cycles, `valid`=0 throughout, issue on the 5th cycle.
- Stall: `stall`=1 for 2 cycles in ISSUE -> `valid`/`inst_reg`/`pc` held for 3 cycles with no `mem_req`. A `load_pc` pulse during the stall is ignored.
- Branch and skip: in ISSUE with `stall`=0, `load_pc`=1, `load_addr`=0x100 and `skip`=1 together -> next `mem_addr`=0x100 and the fetched instruction issues with `valid`=1.
  - Separately, `skip`=1 alone -> next word issues with `ir`=0, `valid`=0 and `pc` incremented.
- Wrap and abort:
  - Branch to 0x1FFF, ack -> `pc`=0.
  - Assert `reset` in FETCH before ack -> `mem_req`=0 at once; a later `mem_ack` pulse leaves `valid`=0 and `pc`=0.
